// File: rtl/vz_pkg.sv
// Shared types and constants for the VZ snapshot loader.
package vz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_PATCH_LO = 3'd4,
    ST_PATCH_HI = 3'd5,
    ST_FIN      = 3'd6,
    ST_ERR      = 3'd7
  } vz_state_e;

  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_BIN   = 8'hF1;

  localparam int TYPE_OFS  = 21;
  localparam int START_OFS = 22;

  // Accepted magic words, byte 0 in the top byte: "VZF0" and " VZF"
  localparam logic [31:0] VZ_MAGIC_A = 32'h565A4630;
  localparam logic [31:0] VZ_MAGIC_B = 32'h20565A46;

  function automatic logic [7:0] magic_byte(input logic [31:0] magic, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = magic[31:24];
      2'd1:    b = magic[23:16];
      2'd2:    b = magic[15:8];
      2'd3:    b = magic[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vz_image_loader_if.sv
// Byte-wide req/ack memory write port of the VZ loader.
interface vz_image_loader_if #(parameter int ADDR_W = 16);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic              mem_ack;

  modport master (output mem_req, output mem_addr, output mem_dout, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_dout, output mem_ack);
endinterface

// File: rtl/vz_image_loader_byte_fifo.sv
// Byte FIFO (power-of-two DEPTH) with occupancy count and synchronous clear.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rd_data   = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array, written on accepted pushes
  always_ff @(posedge clk_sys) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end
endmodule

// File: rtl/vz_image_loader.sv
// VZ snapshot loader: ioctl bytes -> header parse -> FIFO -> req/ack memory writes.
// Optional VZ_MAGIC_CHECK_EN rejects images with a bad magic word or type byte.
module vz_image_loader
  import vz_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  DN_INDEX   = 8'd1,
  parameter int          HDR_LEN    = 24,
  parameter logic [15:0] END_PTR    = 16'h78F9
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic [7:0]        dn_index,
  input  logic              dn_wr,
  input  logic [7:0]        dn_data,
  output logic              dn_wait,
  vz_image_loader_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        img_type,
  output logic [ADDR_W-1:0] img_start,
  output logic [ADDR_W-1:0] img_end
);
  localparam int HC_W = $clog2(HDR_LEN);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PTR_LO = ADDR_W'(END_PTR);
  localparam logic [ADDR_W-1:0] PTR_HI = ADDR_W'(END_PTR + 16'd1);

  vz_state_e         state_r;
  logic              act_s, act_d_r, act_rise_s;
  logic [HC_W-1:0]   hdr_cnt_r;
  logic [ADDR_W-1:0] wr_addr_r, addr_r, img_start_r, img_end_r, hdr_start_s;
  logic              addr_full_r, req_r, done_r, err_r, hdr_bad_s;
  logic [7:0]        dout_r, img_type_r;
  logic              fifo_clr_s, fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [7:0]        fifo_rd_s;
  logic [CW-1:0]     fifo_cnt_s;
  logic              issue_s, wrap_err_s, overrun_s, moving_s;
`ifdef VZ_MAGIC_CHECK_EN
  logic              magic_a_ok_r, magic_b_ok_r, magic_a_s, magic_b_s;
`endif

  assign act_s      = dn_download && (dn_index == DN_INDEX);
  assign act_rise_s = act_s && !act_d_r;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk_sys (clk_sys),     .reset (reset),       .clr   (fifo_clr_s),
    .push    (fifo_push_s), .pop   (fifo_pop_s),  .wr_data (dn_data),
    .rd_data (fifo_rd_s),   .count (fifo_cnt_s),  .full  (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // FIFO control and payload-write issue decisions
  always_comb begin
    fifo_clr_s  = (state_r == ST_ERR) || ((state_r == ST_IDLE) && act_rise_s);
    fifo_push_s = (state_r == ST_PAYLOAD) && act_s && dn_wr;
    moving_s    = (state_r == ST_PAYLOAD) || (state_r == ST_DRAIN);
    issue_s     = 1'b0;
    wrap_err_s  = 1'b0;
    if (moving_s && !req_r && !fifo_empty_s) begin
      issue_s    = !addr_full_r;
      wrap_err_s = addr_full_r;
    end else begin
      issue_s    = 1'b0;
      wrap_err_s = 1'b0;
    end
    fifo_pop_s = issue_s;
    overrun_s  = fifo_push_s && fifo_full_s && !fifo_pop_s;
  end

  // Header field decode for the byte currently on dn_data
  always_comb begin
    hdr_start_s = img_start_r;
    if (hdr_cnt_r == HC_W'(START_OFS)) begin
      hdr_start_s[7:0] = dn_data;
    end else if (hdr_cnt_r == HC_W'(START_OFS + 1)) begin
      hdr_start_s[15:8] = dn_data;
    end else begin
      hdr_start_s = img_start_r;
    end
`ifdef VZ_MAGIC_CHECK_EN
    magic_a_s = magic_a_ok_r;
    magic_b_s = magic_b_ok_r;
    hdr_bad_s = 1'b0;
    if (hdr_cnt_r < HC_W'(4)) begin
      magic_a_s = magic_a_ok_r && (dn_data == magic_byte(VZ_MAGIC_A, hdr_cnt_r[1:0]));
      magic_b_s = magic_b_ok_r && (dn_data == magic_byte(VZ_MAGIC_B, hdr_cnt_r[1:0]));
      hdr_bad_s = !magic_a_s && !magic_b_s;
    end else if (hdr_cnt_r == HC_W'(TYPE_OFS)) begin
      hdr_bad_s = (dn_data != VZ_TYPE_BASIC) && (dn_data != VZ_TYPE_BIN);
    end else begin
      hdr_bad_s = 1'b0;
    end
`else
    hdr_bad_s = 1'b0;
`endif
  end

  // Loader FSM with registered memory port and status outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      act_d_r     <= 1'b0;
      hdr_cnt_r   <= {HC_W{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      addr_full_r <= 1'b0;
      req_r       <= 1'b0;
      dout_r      <= 8'h00;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      img_type_r  <= 8'h00;
      img_start_r <= {ADDR_W{1'b0}};
      img_end_r   <= {ADDR_W{1'b0}};
`ifdef VZ_MAGIC_CHECK_EN
      magic_a_ok_r <= 1'b0;
      magic_b_ok_r <= 1'b0;
`endif
    end else begin
      act_d_r <= act_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (act_rise_s) begin
            err_r       <= 1'b0;
            hdr_cnt_r   <= {HC_W{1'b0}};
            addr_full_r <= 1'b0;
`ifdef VZ_MAGIC_CHECK_EN
            magic_a_ok_r <= 1'b1;
            magic_b_ok_r <= 1'b1;
`endif
            state_r     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!act_s) begin
            state_r <= ST_ERR;
          end else if (dn_wr) begin
            hdr_cnt_r   <= hdr_cnt_r + HC_W'(1);
            img_start_r <= hdr_start_s;
`ifdef VZ_MAGIC_CHECK_EN
            magic_a_ok_r <= magic_a_s;
            magic_b_ok_r <= magic_b_s;
`endif
            if (hdr_cnt_r == HC_W'(TYPE_OFS)) img_type_r <= dn_data;
            if (hdr_bad_s) begin
              state_r <= ST_ERR;
            end else if (hdr_cnt_r == HC_W'(HDR_LEN - 1)) begin
              wr_addr_r <= hdr_start_s;
              img_end_r <= hdr_start_s;
              state_r   <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD, ST_DRAIN: begin
          if (req_r && mem.mem_ack) begin
            req_r     <= 1'b0;
            wr_addr_r <= wr_addr_r + ADDR_W'(1);
            img_end_r <= wr_addr_r + ADDR_W'(1);
            if (&wr_addr_r) addr_full_r <= 1'b1;
          end else if (issue_s) begin
            req_r  <= 1'b1;
            addr_r <= wr_addr_r;
            dout_r <= fifo_rd_s;
          end
          // Top of address space reached with bytes still queued: refuse to wrap
          if (wrap_err_s || overrun_s) begin
            state_r <= ST_ERR;
          end else if ((state_r == ST_PAYLOAD) && !act_s) begin
            state_r <= ST_DRAIN;
          end else if ((state_r == ST_DRAIN) && fifo_empty_s && !req_r) begin
            state_r <= (img_type_r == VZ_TYPE_BASIC) ? ST_PATCH_LO : ST_FIN;
          end
        end
        ST_PATCH_LO: begin
          if (req_r) begin
            if (mem.mem_ack) begin
              req_r   <= 1'b0;
              state_r <= ST_PATCH_HI;
            end
          end else begin
            req_r  <= 1'b1;
            addr_r <= PTR_LO;
            dout_r <= img_end_r[7:0];
          end
        end
        ST_PATCH_HI: begin
          if (req_r) begin
            if (mem.mem_ack) begin
              req_r   <= 1'b0;
              state_r <= ST_FIN;
            end
          end else begin
            req_r  <= 1'b1;
            addr_r <= PTR_HI;
            dout_r <= img_end_r[15:8];
          end
        end
        ST_FIN: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          err_r <= 1'b1;
          req_r <= 1'b0;
          if (!act_s) state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req  = req_r;
  assign mem.mem_addr = addr_r;
  assign mem.mem_dout = dout_r;
  assign dn_wait   = (fifo_cnt_s >= CW'(FIFO_DEPTH - 2)) ||
                     (state_r inside {ST_DRAIN, ST_PATCH_LO, ST_PATCH_HI});
  assign busy      = (state_r != ST_IDLE) && (state_r != ST_ERR);
  assign done      = done_r;
  assign err       = err_r;
  assign img_type  = img_type_r;
  assign img_start = img_start_r;
  assign img_end   = img_end_r;
endmodule

// File: tb/tb_vz_image_loader.sv
// Directed bench for vz_image_loader; memory model acks with a programmable delay.
module tb_vz_image_loader;
  import vz_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dn_download, dn_wr, dn_wait, busy, done, err;
  logic [7:0]  dn_index, dn_data, img_type;
  logic [15:0] img_start, img_end;

  vz_image_loader_if #(.ADDR_W(16)) bus ();

  vz_image_loader dut (
    .clk_sys (clk_sys), .reset (reset), .dn_download (dn_download),
    .dn_index (dn_index), .dn_wr (dn_wr), .dn_data (dn_data),
    .dn_wait (dn_wait), .mem (bus), .busy (busy), .done (done),
    .err (err), .img_type (img_type), .img_start (img_start), .img_end (img_end)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_pass = 0, n_total = 0, n_fail = 0;
  int          ack_delay = 0, ack_cnt = 0, wr_n = 0, req_cycles = 0, done_cnt = 0;
  int          wait_rise_n = 0;
  int          wait_cnt_log [64];
  logic        wait_d = 1'b0;
  logic [15:0] log_addr [256];
  logic [7:0]  log_data [256];

  // Memory responder and event logger, active on the falling edge
  always @(negedge clk_sys) begin
    if (reset) begin
      bus.mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (bus.mem_req) begin
      req_cycles++;
      if (ack_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        if (wr_n < 256) begin
          log_addr[wr_n] = bus.mem_addr;
          log_data[wr_n] = bus.mem_dout;
        end
        wr_n++;
      end else begin
        ack_cnt++;
      end
    end
    if (done) done_cnt++;
    if (dn_wait && !wait_d && wait_rise_n < 64) begin
      wait_cnt_log[wait_rise_n] = int'(dut.fifo_cnt_s);
      wait_rise_n++;
    end
    wait_d = dn_wait;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (dn_wait && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) check("dn_wait_bound", 32'(dn_wait), 32'(1'b0));
    dn_wr = 1'b1;
    dn_data = b;
    tick();
    dn_wr = 1'b0;
    tick();
  endtask

  task automatic send_hdr(input logic [31:0] magic, input logic [7:0] typ,
                          input logic [15:0] start, input int first, input int last);
    logic [7:0] b;
    for (int i = first; i <= last; i++) begin
      b = 8'h00;
      if (i < 4) b = magic[8*(3-i) +: 8];
      else if (i == 21) b = typ;
      else if (i == 22) b = start[7:0];
      else if (i == 23) b = start[15:8];
      send_byte(b);
    end
  endtask

  task automatic start_load();
    dn_index = 8'd1;
    dn_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_load();
    int t;
    dn_download = 1'b0;
    t = 0;
    tick();
    while (busy && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check("busy_bound", 32'(busy), 32'(1'b0));
    tick();
    tick();
  endtask

  initial begin
    int b, db, rb, wb, t;
    dn_download = 1'b0;
    dn_index = 8'd0;
    dn_wr = 1'b0;
    dn_data = 8'h00;
    tick();
    tick();
    // Reset state
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_err", 32'(err), 32'(1'b0));
    check("rst_req", 32'(bus.mem_req), 32'(1'b0));
    check("rst_wait", 32'(dn_wait), 32'(1'b0));
    check("rst_end", 32'(img_end), 32'(16'h0000));
    reset = 1'b0;
    tick();

    // BASIC image: 5 bytes at 7AE9, then end pointer patch
    ack_delay = 0;
    b = wr_n; db = done_cnt;
    start_load();
    send_hdr(VZ_MAGIC_A, 8'hF0, 16'h7AE9, 0, 23);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)));
    end_load();
    check("basic_nwr", 32'(wr_n - b), 32'd7);
    for (int i = 0; i < 5; i++) begin
      check("basic_addr", 32'(log_addr[b+i]), 32'(16'h7AE9 + 16'(i)));
      check("basic_data", 32'(log_data[b+i]), 32'(8'h11 * (i + 1)));
    end
    check("patch_lo_addr", 32'(log_addr[b+5]), 32'(16'h78F9));
    check("patch_lo_data", 32'(log_data[b+5]), 32'(8'hEE));
    check("patch_hi_addr", 32'(log_addr[b+6]), 32'(16'h78FA));
    check("patch_hi_data", 32'(log_data[b+6]), 32'(8'h7A));
    check("basic_done", 32'(done_cnt - db), 32'd1);
    check("basic_end", 32'(img_end), 32'(16'h7AEE));
    check("basic_type", 32'(img_type), 32'(8'hF0));
    check("basic_start", 32'(img_start), 32'(16'h7AE9));
    check("basic_err", 32'(err), 32'(1'b0));

    // Binary image with slow memory: back-pressure, no patch
    ack_delay = 6;
    b = wr_n; db = done_cnt; wb = wait_rise_n;
    start_load();
    send_hdr(VZ_MAGIC_A, 8'hF1, 16'h8000, 0, 23);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
    end_load();
    check("bin_nwr", 32'(wr_n - b), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("bin_addr", 32'(log_addr[b+i]), 32'(16'h8000 + 16'(i)));
      check("bin_data", 32'(log_data[b+i]), 32'(8'h40 + i));
    end
    check("bin_wait_seen", 32'(wait_rise_n > wb), 32'(1'b1));
    check("bin_wait_cnt", 32'(wait_cnt_log[wb]), 32'd6);
    check("bin_done", 32'(done_cnt - db), 32'd1);
    check("bin_err", 32'(err), 32'(1'b0));
    check("bin_end", 32'(img_end), 32'(16'h8010));

    // Truncated header
    ack_delay = 0;
    rb = req_cycles; b = wr_n;
    start_load();
    send_hdr(VZ_MAGIC_A, 8'hF1, 16'h9000, 0, 9);
    end_load();
    check("trunc_err", 32'(err), 32'(1'b1));
    check("trunc_req", 32'(req_cycles - rb), 32'd0);
    check("trunc_busy", 32'(busy), 32'(1'b0));

    // Address overflow at top of memory
    b = wr_n; db = done_cnt;
    start_load();
    check("err_cleared", 32'(err), 32'(1'b0));
    send_hdr(VZ_MAGIC_A, 8'hF1, 16'hFFFE, 0, 23);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i));
    end_load();
    check("ovf_nwr", 32'(wr_n - b), 32'd2);
    check("ovf_addr0", 32'(log_addr[b]), 32'(16'hFFFE));
    check("ovf_addr1", 32'(log_addr[b+1]), 32'(16'hFFFF));
    check("ovf_err", 32'(err), 32'(1'b1));
    check("ovf_done", 32'(done_cnt - db), 32'd0);

    // Reset while a request is outstanding
    ack_delay = 6;
    start_load();
    send_hdr(VZ_MAGIC_A, 8'hF1, 16'h9000, 0, 23);
    send_byte(8'h5A);
    t = 0;
    while (!bus.mem_req && t < 50) begin
      tick();
      t++;
    end
    check("mid_req_up", 32'(bus.mem_req), 32'(1'b1));
    reset = 1'b1;
    #1;
    check("mid_req_drop", 32'(bus.mem_req), 32'(1'b0));
    check("mid_state", 32'(dut.state_r), 32'(ST_IDLE));
    check("mid_busy", 32'(busy), 32'(1'b0));
    check("mid_start", 32'(img_start), 32'(16'h0000));
    check("mid_type", 32'(img_type), 32'(8'h00));
    check("mid_end", 32'(img_end), 32'(16'h0000));
    check("mid_wait", 32'(dn_wait), 32'(1'b0));
    dn_download = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    ack_delay = 0;
    b = wr_n; db = done_cnt;
    start_load();
    send_hdr(VZ_MAGIC_B, 8'hF0, 16'h7000, 0, 23);
    send_byte(8'hAA);
    send_byte(8'hBB);
    end_load();
    check("post_nwr", 32'(wr_n - b), 32'd4);
    check("post_d0", 32'({log_addr[b], log_data[b]}), 32'(24'h7000AA));
    check("post_d1", 32'({log_addr[b+1], log_data[b+1]}), 32'(24'h7001BB));
    check("post_p0", 32'({log_addr[b+2], log_data[b+2]}), 32'(24'h78F902));
    check("post_p1", 32'({log_addr[b+3], log_data[b+3]}), 32'(24'h78FA70));
    check("post_done", 32'(done_cnt - db), 32'd1);

    // Bad magic "VZFX"
    b = wr_n; db = done_cnt;
    start_load();
    send_hdr(32'h565A4658, 8'hF1, 16'hA000, 0, 3);
    tick();
`ifdef VZ_MAGIC_CHECK_EN
    check("magic_err_at3", 32'(err), 32'(1'b1));
`else
    check("magic_noerr_at3", 32'(err), 32'(1'b0));
`endif
    send_hdr(32'h565A4658, 8'hF1, 16'hA000, 4, 23);
    send_byte(8'hC1);
    send_byte(8'hC2);
    end_load();
`ifdef VZ_MAGIC_CHECK_EN
    check("magic_nwr", 32'(wr_n - b), 32'd0);
    check("magic_done", 32'(done_cnt - db), 32'd0);
    check("magic_err", 32'(err), 32'(1'b1));
`else
    check("magic_nwr", 32'(wr_n - b), 32'd2);
    check("magic_done", 32'(done_cnt - db), 32'd1);
    check("magic_err", 32'(err), 32'(1'b0));
    check("magic_end", 32'(img_end), 32'(16'hA002));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
